// File: rtl/skid_buffer.sv
// Two-entry ready/valid slice: every handshake output comes straight from a flop,
// so deq_ready never reaches enq_ready combinationally, and throughput stays at one word per cycle.
module skid_buffer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_aH,
  output logic                  enq_ready,
  input  logic                  enq_valid,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq_ready,
  output logic                  deq_valid,
  output logic [DATA_WIDTH-1:0] deq_data,
  input  logic                  init,
  input  logic [1:0]            init_state,
  input  logic [DATA_WIDTH-1:0] init_main_reg_state,
  input  logic [DATA_WIDTH-1:0] init_skid_reg_state,
  output logic [1:0]            current_state,
  output logic [DATA_WIDTH-1:0] current_main_reg_state,
  output logic [DATA_WIDTH-1:0] current_skid_reg_state
);

  typedef enum logic [1:0] {
    EMPTY   = 2'b00,
    BUSY    = 2'b01,
    FULL    = 2'b10,
    ILLEGAL = 2'b11
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  enq_ready_q, enq_ready_d;
  logic                  deq_valid_q, deq_valid_d;
  logic                  enq_c;
  logic                  deq_c;

  // Handshakes qualified by the registered ready/valid copies of the current state.
  assign enq_c = enq_ready_q & enq_valid;
  assign deq_c = deq_valid_q & deq_ready;

  // Next state and register contents; handshake flags are pre-decoded from the next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (init) begin
      state_d = state_e'(init_state);
      main_d  = init_main_reg_state;
      skid_d  = init_skid_reg_state;
    end else begin
      case (state_q)
        EMPTY: begin
          if (enq_c) begin
            state_d = BUSY;
            main_d  = enq_data;
          end
        end
        BUSY: begin
          if (enq_c && deq_c) begin
            main_d = enq_data;
          end else if (enq_c) begin
            state_d = FULL;
            skid_d  = enq_data;
          end else if (deq_c) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq_c) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          // Unreachable encoding: recover to EMPTY and drop anything offered.
          state_d = EMPTY;
        end
      endcase
    end
    enq_ready_d = (state_d != FULL);
    deq_valid_d = (state_d == BUSY) || (state_d == FULL);
  end

  // State, data and handshake flops with asynchronous clear.
  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      enq_ready_q <= 1'b1;
      deq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      enq_ready_q <= enq_ready_d;
      deq_valid_q <= deq_valid_d;
    end
  end

  assign enq_ready              = enq_ready_q;
  assign deq_valid              = deq_valid_q;
  assign deq_data               = main_q;
  assign current_state          = 2'(state_q);
  assign current_main_reg_state = main_q;
  assign current_skid_reg_state = skid_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: the driver pushes accepted words into a queue,
// a negedge monitor checks handshakes and pops/compares on every dequeue.
module tb_skid_buffer;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_aH;
  logic          enq_ready;
  logic          enq_valid;
  logic [DW-1:0] enq_data;
  logic          deq_ready;
  logic          deq_valid;
  logic [DW-1:0] deq_data;
  logic          init;
  logic [1:0]    init_state;
  logic [DW-1:0] init_main_reg_state;
  logic [DW-1:0] init_skid_reg_state;
  logic [1:0]    current_state;
  logic [DW-1:0] current_main_reg_state;
  logic [DW-1:0] current_skid_reg_state;

  skid_buffer #(.DATA_WIDTH(DW)) dut (
    .clk                    (clk),
    .rst_aH                 (rst_aH),
    .enq_ready              (enq_ready),
    .enq_valid              (enq_valid),
    .enq_data               (enq_data),
    .deq_ready              (deq_ready),
    .deq_valid              (deq_valid),
    .deq_data               (deq_data),
    .init                   (init),
    .init_state             (init_state),
    .init_main_reg_state    (init_main_reg_state),
    .init_skid_reg_state    (init_skid_reg_state),
    .current_state          (current_state),
    .current_main_reg_state (current_main_reg_state),
    .current_skid_reg_state (current_skid_reg_state)
  );

  always #5 clk = ~clk;

  // Reference model: the words held by the slice, oldest first.
  logic [DW-1:0] exp_q[$];
  int            occ_start;
  logic          mon_en;
  int            n_checks;
  int            n_errors;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; inputs change 1 time unit after the rising edge.
  task automatic step(input logic ev, input logic [DW-1:0] d, input logic dr);
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    occ_start = exp_q.size();
    if (ev && occ_start < 2) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes follow occupancy; dequeued words leave in acceptance order.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("enq_ready", 32'(enq_ready), 32'(occ_start < 2));
      chk("deq_valid", 32'(deq_valid), 32'(occ_start > 0));
      chk("state", 32'(current_state), 32'(occ_start));
      if (occ_start > 0) begin
        chk("deq_data", deq_data, exp_q[0]);
        if (occ_start == 2) chk("skid", current_skid_reg_state, exp_q[1]);
        if (deq_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mon_en = 1'b0;
    occ_start = 0;
    rst_aH = 1'b1;
    enq_valid = 1'b0;
    enq_data = '0;
    deq_ready = 1'b0;
    init = 1'b0;
    init_state = 2'b00;
    init_main_reg_state = '0;
    init_skid_reg_state = '0;
    #1;
    chk("rst_enq_ready", 32'(enq_ready), 32'd1);
    chk("rst_deq_valid", 32'(deq_valid), 32'd0);
    chk("rst_deq_data", deq_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_aH = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single pass, then drain.
    step(1'b1, 32'hA5A5A5A5, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Fill to two words; third offer must be refused.
    step(1'b1, 32'h1, 1'b0);
    step(1'b1, 32'h2, 1'b0);
    step(1'b1, 32'h3, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Streaming at full rate.
    for (int i = 0; i < 100; i++) step(1'b1, 32'(i), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Random backpressure.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(1, 0)), $urandom, 1'($urandom_range(1, 0)));
    repeat (3) step(1'b0, 32'h0, 1'b1);
    chk("drained", 32'(exp_q.size()), 32'd0);

    // Async reset mid-cycle with two words stored.
    step(1'b1, 32'hDEAD0001, 1'b0);
    step(1'b1, 32'hDEAD0002, 1'b0);
    mon_en = 1'b0;
    enq_valid = 1'b0;
    #2;
    rst_aH = 1'b1;
    #1;
    chk("arst_enq_ready", 32'(enq_ready), 32'd1);
    chk("arst_deq_valid", 32'(deq_valid), 32'd0);
    chk("arst_deq_data", deq_data, 32'd0);
    chk("arst_state", 32'(current_state), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_aH = 1'b0;
    @(posedge clk);
    #1;

    // Load illegal state: decodes as EMPTY, then recovers, dropping the offer.
    init = 1'b1;
    init_state = 2'b11;
    init_main_reg_state = 32'h55;
    init_skid_reg_state = 32'h66;
    enq_valid = 1'b1;
    enq_data = 32'h77;
    deq_ready = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    chk("ill_state", 32'(current_state), 32'd3);
    chk("ill_enq_ready", 32'(enq_ready), 32'd1);
    chk("ill_deq_valid", 32'(deq_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("ill_recover_state", 32'(current_state), 32'd0);
    chk("ill_recover_valid", 32'(deq_valid), 32'd0);
    enq_valid = 1'b0;

    // Load FULL with main=7, skid=9 and drain in order.
    init = 1'b1;
    init_state = 2'b10;
    init_main_reg_state = 32'h7;
    init_skid_reg_state = 32'h9;
    deq_ready = 1'b0;
    @(posedge clk);
    #1;
    init = 1'b0;
    exp_q.push_back(32'h7);
    exp_q.push_back(32'h9);
    mon_en = 1'b1;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    chk("init_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
